// File: rtl/axi4_interconnect.sv
// rtl/axi4_interconnect.sv - single-master single-slave AXI4 pass-through with one skid slice per channel
// Also mirrors the master-side bus onto a passive monitor port.

module axi4_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             live;
    logic             in_fire;
    logic             out_load;

    // live keeps ready low through reset and lets it rise on the first edge after release
    assign in_ready = live & ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_load = out_ready | ~out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live       <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            live <= 1'b1;
            if (out_load) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= in_fire;
                end
            end else if (in_fire) begin
                skid_valid <= 1'b1;
            end
        end
    end

    // Payload holds its last value; only loads move it, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (out_load) begin
            if (skid_valid) begin
                out_data <= skid_data;
            end else if (in_fire) begin
                out_data <= in_data;
            end
        end else if (in_fire) begin
            skid_data <= in_data;
        end
    end
endmodule

module axi4_interconnect #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic [1:0]              s_awburst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [2:0]              s_arsize,
    input  logic [1:0]              s_arburst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready,

    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,

    output logic [ID_WIDTH-1:0]     mon_awid,
    output logic [ADDR_WIDTH-1:0]   mon_awaddr,
    output logic [7:0]              mon_awlen,
    output logic [2:0]              mon_awsize,
    output logic [1:0]              mon_awburst,
    output logic                    mon_awvalid,
    output logic                    mon_awready,
    output logic [DATA_WIDTH-1:0]   mon_wdata,
    output logic [DATA_WIDTH/8-1:0] mon_wstrb,
    output logic                    mon_wlast,
    output logic                    mon_wvalid,
    output logic                    mon_wready,
    output logic [ID_WIDTH-1:0]     mon_bid,
    output logic [1:0]              mon_bresp,
    output logic                    mon_bvalid,
    output logic                    mon_bready,
    output logic [ID_WIDTH-1:0]     mon_arid,
    output logic [ADDR_WIDTH-1:0]   mon_araddr,
    output logic [7:0]              mon_arlen,
    output logic [2:0]              mon_arsize,
    output logic [1:0]              mon_arburst,
    output logic                    mon_arvalid,
    output logic                    mon_arready,
    output logic [ID_WIDTH-1:0]     mon_rid,
    output logic [DATA_WIDTH-1:0]   mon_rdata,
    output logic [1:0]              mon_rresp,
    output logic                    mon_rlast,
    output logic                    mon_rvalid,
    output logic                    mon_rready
);
    localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 13;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3;

    axi4_reg_slice #(.WIDTH(AX_W)) u_aw (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_data   ({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst}),
        .in_valid  (s_awvalid),
        .in_ready  (s_awready),
        .out_data  ({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst}),
        .out_valid (m_awvalid),
        .out_ready (m_awready)
    );

    axi4_reg_slice #(.WIDTH(W_W)) u_w (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_data   ({s_wdata, s_wstrb, s_wlast}),
        .in_valid  (s_wvalid),
        .in_ready  (s_wready),
        .out_data  ({m_wdata, m_wstrb, m_wlast}),
        .out_valid (m_wvalid),
        .out_ready (m_wready)
    );

    axi4_reg_slice #(.WIDTH(B_W)) u_b (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_data   ({m_bid, m_bresp}),
        .in_valid  (m_bvalid),
        .in_ready  (m_bready),
        .out_data  ({s_bid, s_bresp}),
        .out_valid (s_bvalid),
        .out_ready (s_bready)
    );

    axi4_reg_slice #(.WIDTH(AX_W)) u_ar (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_data   ({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}),
        .in_valid  (s_arvalid),
        .in_ready  (s_arready),
        .out_data  ({m_arid, m_araddr, m_arlen, m_arsize, m_arburst}),
        .out_valid (m_arvalid),
        .out_ready (m_arready)
    );

    axi4_reg_slice #(.WIDTH(R_W)) u_r (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_data   ({m_rid, m_rdata, m_rresp, m_rlast}),
        .in_valid  (m_rvalid),
        .in_ready  (m_rready),
        .out_data  ({s_rid, s_rdata, s_rresp, s_rlast}),
        .out_valid (s_rvalid),
        .out_ready (s_rready)
    );

    // Monitor taps the master-side nets directly, zero latency.
    assign mon_awid    = s_awid;
    assign mon_awaddr  = s_awaddr;
    assign mon_awlen   = s_awlen;
    assign mon_awsize  = s_awsize;
    assign mon_awburst = s_awburst;
    assign mon_awvalid = s_awvalid;
    assign mon_awready = s_awready;
    assign mon_wdata   = s_wdata;
    assign mon_wstrb   = s_wstrb;
    assign mon_wlast   = s_wlast;
    assign mon_wvalid  = s_wvalid;
    assign mon_wready  = s_wready;
    assign mon_bid     = s_bid;
    assign mon_bresp   = s_bresp;
    assign mon_bvalid  = s_bvalid;
    assign mon_bready  = s_bready;
    assign mon_arid    = s_arid;
    assign mon_araddr  = s_araddr;
    assign mon_arlen   = s_arlen;
    assign mon_arsize  = s_arsize;
    assign mon_arburst = s_arburst;
    assign mon_arvalid = s_arvalid;
    assign mon_arready = s_arready;
    assign mon_rid     = s_rid;
    assign mon_rdata   = s_rdata;
    assign mon_rresp   = s_rresp;
    assign mon_rlast   = s_rlast;
    assign mon_rvalid  = s_rvalid;
    assign mon_rready  = s_rready;
endmodule

// File: tb/tb_axi4_interconnect.sv
// tb/tb_axi4_interconnect.sv - directed self-checking bench for axi4_interconnect
module tb_axi4_interconnect;
    logic aclk, aresetn;
    logic [3:0]  s_awid, s_arid, m_bid, m_rid, s_bid, s_rid, m_awid, m_arid;
    logic [31:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
    logic [7:0]  s_awlen, s_arlen, m_awlen, m_arlen;
    logic [2:0]  s_awsize, s_arsize, m_awsize, m_arsize;
    logic [1:0]  s_awburst, s_arburst, m_awburst, m_arburst;
    logic s_awvalid, s_awready, m_awvalid, m_awready;
    logic s_arvalid, s_arready, m_arvalid, m_arready;
    logic [31:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [3:0]  s_wstrb, m_wstrb;
    logic s_wlast, s_wvalid, s_wready, m_wlast, m_wvalid, m_wready;
    logic [1:0]  s_bresp, m_bresp, s_rresp, m_rresp;
    logic s_bvalid, s_bready, m_bvalid, m_bready;
    logic s_rlast, s_rvalid, s_rready, m_rlast, m_rvalid, m_rready;
    logic [3:0]  mon_awid, mon_arid, mon_bid, mon_rid, mon_wstrb;
    logic [31:0] mon_awaddr, mon_araddr, mon_wdata, mon_rdata;
    logic [7:0]  mon_awlen, mon_arlen;
    logic [2:0]  mon_awsize, mon_arsize;
    logic [1:0]  mon_awburst, mon_arburst, mon_bresp, mon_rresp;
    logic mon_awvalid, mon_awready, mon_wlast, mon_wvalid, mon_wready;
    logic mon_bvalid, mon_bready, mon_arvalid, mon_arready;
    logic mon_rlast, mon_rvalid, mon_rready;

    int total = 0;
    int bad   = 0;

    axi4_interconnect dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .mon_awid(mon_awid), .mon_awaddr(mon_awaddr), .mon_awlen(mon_awlen), .mon_awsize(mon_awsize),
        .mon_awburst(mon_awburst), .mon_awvalid(mon_awvalid), .mon_awready(mon_awready),
        .mon_wdata(mon_wdata), .mon_wstrb(mon_wstrb), .mon_wlast(mon_wlast),
        .mon_wvalid(mon_wvalid), .mon_wready(mon_wready),
        .mon_bid(mon_bid), .mon_bresp(mon_bresp), .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
        .mon_arid(mon_arid), .mon_araddr(mon_araddr), .mon_arlen(mon_arlen), .mon_arsize(mon_arsize),
        .mon_arburst(mon_arburst), .mon_arvalid(mon_arvalid), .mon_arready(mon_arready),
        .mon_rid(mon_rid), .mon_rdata(mon_rdata), .mon_rresp(mon_rresp), .mon_rlast(mon_rlast),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0; s_awvalid = 0;
        s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0; s_arvalid = 0;
        s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_wvalid = 0;
        s_bready = 1; s_rready = 1;
        m_awready = 1; m_wready = 1; m_arready = 1;
        m_bid = 0; m_bresp = 0; m_bvalid = 0;
        m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_valids"}, {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, 5'h00);
        chk({tag, "_readys"}, {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'h00);
    endtask

    int exp_rdy [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    int exp_mv  [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    int exp_md  [8] = '{0, 'hC0, 'hC0, 'hC0, 'hC0, 'hC1, 'hC2, 'hC3};

    initial begin
        int sent, rcv, wn, rn, bn, awn, arn, dly;
        idle();
        aresetn = 1'b0;
        #12;
        chk_all_low("rst");
        tick();
        chk_all_low("rst_edge");
        #2 aresetn = 1'b1;
        #1 chk("rdy_before_edge", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'h00);
        tick();
        chk("rdy_after_edge", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'h1f);
        chk("valid_after_rst", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, 5'h00);

        // single write burst
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                s_awid = 3; s_awaddr = 32'h1000; s_awlen = 3; s_awsize = 2; s_awburst = 1; s_awvalid = 1;
            end
            s_wdata = 32'hA0 + i; s_wstrb = 4'hF; s_wlast = (i == 3); s_wvalid = 1;
            tick();
            if (i == 0) begin
                s_awvalid = 0;
                chk("wr_awvalid", m_awvalid, 1);
                chk("wr_aw_payload", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst},
                    {4'd3, 32'h1000, 8'd3, 3'd2, 2'd1});
            end
            chk("wr_wvalid", m_wvalid, 1);
            chk("wr_wbeat", {m_wdata, m_wstrb, m_wlast}, {32'hA0 + i, 4'hF, i == 3});
        end
        s_wvalid = 0;
        tick();
        chk("wr_drained", {m_awvalid, m_wvalid}, 2'b00);
        m_bid = 3; m_bresp = 0; m_bvalid = 1;
        #1 chk("wr_bready", m_bready, 1);
        tick();
        m_bvalid = 0;
        chk("wr_bvalid", s_bvalid, 1);
        chk("wr_b_payload", {s_bid, s_bresp}, {4'd3, 2'd0});
        tick();
        chk("wr_b_done", s_bvalid, 0);

        // read burst of eight, no bubbles
        s_arid = 5; s_araddr = 32'h2000; s_arlen = 7; s_arsize = 2; s_arburst = 1; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        chk("rd_ar", {m_arvalid, m_arid, m_araddr, m_arlen}, {1'b1, 4'd5, 32'h2000, 8'd7});
        for (int i = 0; i < 8; i++) begin
            m_rid = 5; m_rdata = 32'hB0 + i; m_rresp = 0; m_rlast = (i == 7); m_rvalid = 1;
            tick();
            chk("rd_rvalid", s_rvalid, 1);
            chk("rd_rbeat", {s_rid, s_rdata, s_rlast}, {4'd5, 32'hB0 + i, i == 7});
        end
        m_rvalid = 0;
        tick();
        chk("rd_done", s_rvalid, 0);

        // backpressure: downstream stall for three cycles
        sent = 0; rcv = 0;
        for (int c = 0; c < 10; c++) begin
            m_wready = !(c >= 1 && c <= 3);
            s_wvalid = (sent < 4); s_wdata = 32'hC0 + sent; s_wstrb = 4'hF; s_wlast = (sent == 3);
            #1;
            if (c < 8) begin
                chk("bp_swready", s_wready, exp_rdy[c]);
                chk("bp_mwvalid", m_wvalid, exp_mv[c]);
                if (exp_mv[c] != 0) chk("bp_mwdata", m_wdata, exp_md[c]);
            end
            if (m_wvalid && m_wready) begin
                chk("bp_order", m_wdata, 32'hC0 + rcv);
                chk("bp_last", m_wlast, rcv == 3);
                rcv++;
            end
            if (s_wvalid && s_wready) sent++;
            tick();
        end
        chk("bp_count", rcv, 4);
        idle();
        tick();

        // concurrent write and read bursts
        wn = 0; rn = 0; bn = 0; awn = 0; arn = 0;
        for (int c = 0; c < 10; c++) begin
            s_awvalid = (c == 0); s_awid = 1; s_awaddr = 32'h3000; s_awlen = 3; s_awsize = 2; s_awburst = 1;
            s_arvalid = (c == 0); s_arid = 2; s_araddr = 32'h4000; s_arlen = 3; s_arsize = 2; s_arburst = 1;
            s_wvalid = (c < 4); s_wdata = 32'hD0 + c; s_wstrb = 4'hF; s_wlast = (c == 3);
            m_rvalid = (c >= 2 && c <= 5); m_rid = 2; m_rdata = 32'hE0 + c - 2; m_rlast = (c == 5);
            m_bvalid = (c == 6); m_bid = 1; m_bresp = 0;
            #1;
            chk("mon_aw", {mon_awvalid, mon_awid, mon_awaddr, mon_awlen}, {s_awvalid, 4'd1, 32'h3000, 8'd3});
            chk("mon_ar", {mon_arvalid, mon_arid, mon_araddr, mon_arlen}, {s_arvalid, 4'd2, 32'h4000, 8'd3});
            chk("mon_w", {mon_wvalid, mon_wdata, mon_wstrb, mon_wlast}, {s_wvalid, s_wdata, 4'hF, s_wlast});
            chk("mon_rdy", {mon_awready, mon_wready, mon_arready, mon_bready, mon_rready},
                {s_awready, s_wready, s_arready, 1'b1, 1'b1});
            chk("mon_r", {mon_rvalid, mon_rid, mon_rdata, mon_rresp, mon_rlast},
                {s_rvalid, s_rid, s_rdata, s_rresp, s_rlast});
            chk("mon_b", {mon_bvalid, mon_bid, mon_bresp}, {s_bvalid, s_bid, s_bresp});
            if (m_awvalid) awn++;
            if (m_arvalid) arn++;
            if (m_wvalid) begin
                chk("cc_w", m_wdata, 32'hD0 + wn);
                wn++;
            end
            if (s_rvalid) begin
                chk("cc_r", {s_rid, s_rdata, s_rlast}, {4'd2, 32'hE0 + rn, rn == 3});
                rn++;
            end
            if (s_bvalid) begin
                chk("cc_b", s_bid, 1);
                bn++;
            end
            tick();
        end
        chk("cc_counts", {awn[7:0], arn[7:0], wn[7:0], rn[7:0], bn[7:0]}, {8'd1, 8'd1, 8'd4, 8'd4, 8'd1});
        idle();
        tick();

        // reset in the middle of traffic
        s_wvalid = 1; s_wdata = 32'hFF; m_wready = 0;
        s_awvalid = 1; m_awready = 0;
        m_rvalid = 1; m_rdata = 32'h55;
        dly = int'($urandom_range(0, 200));
        if (dly % 10 == 4) dly++;
        #(dly);
        aresetn = 1'b0;
        #1 chk_all_low("mid_rst");
        tick();
        chk_all_low("mid_rst_edge");
        idle();
        #2 aresetn = 1'b1;
        #1 chk("mid_rdy_pre", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'h00);
        tick();
        chk("mid_rdy_post", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'h1f);
        chk("mid_empty", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, 5'h00);
        s_awid = 6; s_awaddr = 32'h5000; s_awlen = 0; s_awsize = 2; s_awburst = 1; s_awvalid = 1;
        s_wdata = 32'h77; s_wstrb = 4'h3; s_wlast = 1; s_wvalid = 1;
        tick();
        idle();
        chk("post_aw", {m_awvalid, m_awid, m_awaddr, m_awlen}, {1'b1, 4'd6, 32'h5000, 8'd0});
        chk("post_w", {m_wvalid, m_wdata, m_wstrb, m_wlast}, {1'b1, 32'h77, 4'h3, 1'b1});
        m_bvalid = 1; m_bid = 6; m_bresp = 2;
        tick();
        m_bvalid = 0;
        chk("post_b", {s_bvalid, s_bid, s_bresp}, {1'b1, 4'd6, 2'd2});
        tick();
        chk("post_idle", {m_awvalid, m_wvalid, s_bvalid}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_interconnect.md
# axi4_interconnect

Single-master, single-slave AXI4 interconnect used in the AXI4 VIP environment. It connects the master-side interface to the slave-side interface through one register slice per channel: AW, W, B, AR and R. It also drives a passive monitor port that mirrors every upstream (master-side) signal. It has no address decoding and no arbitration; the only function is lossless, in-order, full-throughput transfer with one cycle of registered latency.

## Interface
- ADDR_WIDTH, 32, address width of AW/AR.
- DATA_WIDTH, 32, data width of W/R; strobe width is DATA_WIDTH/8.
- ID_WIDTH, 4, transaction ID width on all channels.
- aclk  in  1  sole clock; all logic is sampled on the rising edge.
- aresetn  in  1  asynchronous, active-low reset; deassertion is taken synchronously to aclk.
- s_aw{id,addr,len[8],size[3],burst[2],valid}  in, s_awready out  upstream write-address channel, driven by the master.
- s_w{data,strb,last,valid}  in, s_wready out  upstream write-data channel.
- s_b{id,resp[2],valid}  out, s_bready in  upstream write-response channel.
- s_ar{id,addr,len[8],size[3],burst[2],valid}  in, s_arready out  upstream read-address channel.
- s_r{id,data,resp[2],last,valid}  out, s_rready in  upstream read-data channel.
- m_aw*/m_w*/m_ar* out (ready in), m_b*/m_r* in (ready out)  the same five channels toward the slave, with directions mirrored.
- mon_*  out  one output per s_* signal above, same name suffix and width.

## Operation
- Each channel has a two-entry skid buffer: a main register and a skid register. The forward direction is AW, W and AR from s to m; the reverse direction is B and R from m to s.
- Input side: ready = NOT skid_full.
  - A beat is accepted when valid && ready.
  - If the output register is empty, or is emptying in the same cycle, the beat goes to the output register. Otherwise it goes to skid.
- Output side: the output register presents valid plus payload.
  - On valid && ready the output register reloads from skid if skid holds data. Otherwise it reloads from the input if a beat arrives in that cycle. Otherwise it empties.
- Payload is never modified. This includes ID, LEN, LAST, STRB and RESP.
- Beat order is preserved per channel. The channels are independent, and no inter-channel ordering is enforced; for example, W may precede AW.
- Payload registers change only on load. Payload while valid is low is don't-care, but the implementation holds the last value.
- Monitor outputs are combinational copies of the s_* nets: inputs as received, outputs as driven. A monitor sees exactly the master's view of the bus, with zero latency.

## Timing
- Reset: while aresetn=0, every valid output (m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid) is 0. Every ready output (s_awready, s_wready, s_arready, m_bready, m_rready) is also 0. Both buffers of every slice are empty.
- Ready outputs rise at the first rising edge of aclk after aresetn deasserts.
- Reset asserted mid-transfer: all buffered beats are discarded immediately and all valid outputs drop asynchronously. Recovery requires no further action.
- Latency: a beat accepted at edge N appears on the far side with valid=1 after edge N (first visible in cycle N+1).
- Throughput: one beat per cycle per channel with continuous ready. There are no bubbles.
- Backpressure:
  - A downstream stall holds the output register stable. valid must not drop and payload must not change until the handshake.
  - The next beat is captured in skid, and input ready falls one cycle later.
  - When ready returns, the skid beat is emitted next, then new input.
- Simultaneous events:
  - A simultaneous input accept and output handshake with skid empty passes the new beat straight into the output register.
  - Skid full with an output handshake: skid moves to the output register and input ready rises the next cycle.
- Upstream protocol: AXI4 rules (valid not dependent on ready, stable payload until handshake) are assumed of the upstream sources. The block itself always complies on its outputs.

## Test plan
- Single write: AW id=3 addr=0x1000 len=3 size=2 burst=INCR, then four W beats 0xA0..0xA3 strb=0xF with last on beat 4. Slave returns B id=3 resp=OKAY.
  - Required: identical AW and W beats on m_* one cycle later.
  - Required: s_bvalid with id=3 resp=0 one cycle after m_bvalid.
- Read burst: AR id=5 addr=0x2000 len=7. Slave returns eight R beats 0xB0..0xB7 with rready held high.
  - Required: eight consecutive s_rvalid cycles with no gaps, data in order, last only on the 8th beat.
- Backpressure: m_wready held 0 for 3 cycles during a 4-beat burst.
  - Required: m_w payload stable while stalled, s_wready=0 after skid fills, no beat lost or duplicated, order 0..3 preserved.
- Concurrent channels: a write burst and a read burst issued in the same cycle.
  - Required: both complete independently and monitor nets equal the s_* nets every cycle.
- Reset mid-burst: aresetn pulled low at a random time in 0..200 time units during traffic, held for at least one aclk edge.
  - Required: all valid outputs and ready outputs are 0 during reset, buffers are empty, ready outputs return to 1 at the first edge after release, and a following transfer completes correctly.
